snake_body: RTL and testbench
=============================

# snake_body

Holds the snake body as a head coordinate plus a ring of 2-bit link directions. Continuously streams the segments, one per clock from head to tail, into the VGA renderer's row-buffer inputs (`snake_*`). Applies game moves and growth between passes, and reports wall and self collisions. Sits between the game tick/controller logic and the `vga` block.

## Interface

**Parameters**
- `GAME_WIDTH`, default 18: playfield columns; x range 1..GAME_WIDTH.
- `GAME_HEIGHT`, default 13: playfield rows; y range 1..GAME_HEIGHT.
- `MAX_LEN`, default 32: ring depth; must be a power of two, at least 4.
- `START_LEN`, default 3: body length after reset.
- `START_X`, default 5; `START_Y`, default 7: head position after reset. The body extends leftward from it.

**Ports**
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset. One clock; reset is synchronous and active-low.
- `game_rst_n`, in, 1: synchronous active-low game restart. Identical effect to `rst_n`.
- `step`, in, 1: one-cycle move request.
- `step_dir`, in, 2: requested heading. 0 = up (y-1), 1 = down (y+1), 2 = left (x-1), 3 = right (x+1).
- `grow`, in, 1: sampled with `step`; keep the tail on this move.
- `snake_x`, out, 5; `snake_y`, out, 4: streamed segment position.
- `snake_dir`, out, 2: direction from this segment to the next one toward the tail.
- `snake_first`, out, 1: segment is the head. `snake_last`, out, 1: segment is the tail.
- `snake_valid`, out, 1: stream output is valid this cycle.
- `snake_head_x`, out, 5; `snake_head_y`, out, 4: current head position.
- `length`, out, 6: current body length.
- `failure`, out, 1: sticky wall or self hit.
- `success`, out, 1: sticky; set when `length == MAX_LEN`.
- `step_done`, out, 1: one-cycle pulse when a step's result is final.

## Operation

**State**
- `head_x`, `head_y`, `head_ptr` (log2 MAX_LEN bits), `len`.
- `ring[MAX_LEN]` of 2 bits. `ring[head_ptr - i]` holds the link from segment i to segment i+1.

**FSM, STREAM**
- Walker starts at the head and `head_ptr`. Index i runs from 0 to len-1.
- Each cycle outputs the walker position and `ring[ptr]`, with `valid` = 1, `first` = (i==0), `last` = (i==len-1).
- Then the walker steps one cell along `ring[ptr]` and decrements `ptr` mod MAX_LEN.
- After the `last` cycle, go to GAP.

**FSM, GAP**
- Exactly one cycle with `valid` = 0.
- Applies the pending step, if any, then returns to STREAM from the (new) head.

**Step latch**
- `step` latches `step_dir` and `grow` into a pending slot.
- A `step` arriving while the slot is already full is dropped.
- Steps are ignored while `failure` = 1.

**Applying a step in GAP**
- Reversal: if `step_dir == ring[head_ptr]` (pointing back at the neck), use the opposite of it, i.e. keep the current heading.
- Compute the new head position.
- If the new head is outside 1..GAME_WIDTH or 1..GAME_HEIGHT: set `failure`; the body is unchanged.
- Otherwise:
  - `head_ptr` increments.
  - `ring[new head_ptr]` is written with the opposite of the move direction.
  - The head position is updated.
  - If `grow` and `len < MAX_LEN`: `len` increments.
  - If `len` becomes MAX_LEN: `success` is set.
- Opposite direction is `{d[1], ~d[0]}`.

**Self-hit check**
- During the first STREAM pass after an applied step, any segment with i > 0 whose position equals the head sets `failure`.
- The tail has already been dropped at that point, so moving into the vacated tail cell is legal.

**Result and restart**
- `step_done` pulses in the GAP cycle that ends that pass. A wall hit is reported in the same GAP.
- `game_rst_n` or `rst_n` low restores the reset state at the next edge, including mid-pass. The pending step is discarded.

## Timing

**Reset values**
- `snake_valid`, `snake_first`, `snake_last`, `failure`, `success`, `step_done` = 0.
- `snake_x`, `snake_y`, `snake_dir` = 0.
- `length` = START_LEN; head = (START_X, START_Y).
- All `ring` entries = 2 (left); `head_ptr` = 0.

**Stream timing**
- FSM enters STREAM on the first cycle after reset release.
- Outputs are registered: the segment for index i appears one cycle after the walker holds it.
- Pass period = len + 1 cycles, continuous, with no backpressure.

**Step latency**
- A `step` is applied at the next GAP.
- `step_done` fires at the following GAP: latency from `step` is at most 2·len + 2 cycles.
- A new pending step may be applied in the same GAP where `step_done` fires.

## Configuration

- `SNAKE_SELF_HIT_EN` defined: self-collision check compiled in, as described above.
- Not defined: the comparator is removed. Only wall hits set `failure`; `step_done` timing is unchanged.

## Test plan

1. **Reset stream**
   - Stimulus: reset, default parameters.
   - Required: stream (5,7,dir 2,first), (4,7,2), (3,7,2,last), then one cycle with `valid` = 0. Repeats every 4 cycles.
2. **Move and grow**
   - Stimulus: `step` right, no grow.
   - Required: next pass (6,7), (5,7), (4,7); `length` = 3.
   - Stimulus: then `step` right with grow.
   - Required: (7,7), (6,7), (5,7), (4,7); `length` = 4; `step_done` pulses once per step.
3. **Reversal**
   - Stimulus: from reset, `step` left.
   - Required: treated as right; head becomes (6,7); `failure` stays 0.
4. **Wall hit**
   - Stimulus: step right until head x = 18, then one more right.
   - Required: `failure` = 1; head stays (18,7); later steps are ignored.
5. **Self hit**
   - Stimulus: two grow-right steps (head (7,7), length 5), then up, left, down.
   - Required: `failure` = 1 at the `step_done` of the final step.
   - With `SNAKE_SELF_HIT_EN` undefined: `failure` stays 0.
6. **Full and mid-pass restart**
   - Stimulus: MAX_LEN = 4, one grow step.
   - Required: `success` = 1.
   - Stimulus: pulse `game_rst_n` low mid-pass.
   - Required: `valid` = 0 the next cycle; the reset stream of scenario 1 resumes.

Source files
------------

// File: rtl/snake_body.sv
// Snake body store and segment streamer: head coordinate plus a ring of link directions,
// streamed head-to-tail once per pass. Optional self-collision check: define SNAKE_SELF_HIT_EN.
module snake_body #(
    parameter int GAME_WIDTH  = 18,
    parameter int GAME_HEIGHT = 13,
    parameter int MAX_LEN     = 32,
    parameter int START_LEN   = 3,
    parameter int START_X     = 5,
    parameter int START_Y     = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_rst_n,
    input  logic       step,
    input  logic [1:0] step_dir,
    input  logic       grow,
    output logic [4:0] snake_x,
    output logic [3:0] snake_y,
    output logic [1:0] snake_dir,
    output logic       snake_first,
    output logic       snake_last,
    output logic       snake_valid,
    output logic [4:0] snake_head_x,
    output logic [3:0] snake_head_y,
    output logic [5:0] length,
    output logic       failure,
    output logic       success,
    output logic       step_done
);

    localparam int PW = $clog2(MAX_LEN);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [5:0] X_MAX     = 6'(GAME_WIDTH);
    localparam logic [4:0] Y_MAX     = 5'(GAME_HEIGHT);
    localparam logic [5:0] LEN_MAX   = 6'(MAX_LEN);
    localparam logic [5:0] LEN_START = 6'(START_LEN);
    localparam logic [4:0] X_START   = 5'(START_X);
    localparam logic [3:0] Y_START   = 4'(START_Y);

    typedef enum logic {
        ST_STREAM,
        ST_GAP
    } state_t;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    state_t         state;
    logic [4:0]     head_x;
    logic [3:0]     head_y;
    logic [PW-1:0]  head_ptr;
    logic [5:0]     len;
    logic [1:0]     ring [MAX_LEN];

    // Walker: the segment about to be presented on the registered stream outputs.
    logic [4:0]     wx;
    logic [3:0]     wy;
    logic [PW-1:0]  wptr;
    logic [5:0]     widx;

    logic           pend_valid;
    logic [1:0]     pend_dir;
    logic           pend_grow;
    logic           judge_pending;

    logic           restart;
    logic [1:0]     walk_dir;
    logic           walk_last;
    logic [1:0]     move_dir;
    logic [5:0]     nx;
    logic [4:0]     ny;
    logic           wall_hit;
    logic           apply_step;
    logic           move_ok;
    logic [PW-1:0]  next_ptr;
    logic           self_hit;

    assign restart   = !rst_n || !game_rst_n;
    assign walk_dir  = ring[wptr];
    assign walk_last = (widx == len - 6'd1);
    assign next_ptr  = head_ptr + PW'(1);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        move_dir = pend_dir;
        if (pend_dir == ring[head_ptr]) begin
            move_dir = opposite(pend_dir);
        end
        nx = {1'b0, head_x};
        ny = {1'b0, head_y};
        case (move_dir)
            DIR_UP:   ny = ny - 5'd1;
            DIR_DOWN: ny = ny + 5'd1;
            DIR_LEFT: nx = nx - 6'd1;
            default:  nx = nx + 6'd1;
        endcase
        wall_hit = (nx == 6'd0) || (nx > X_MAX) || (ny == 5'd0) || (ny > Y_MAX);
    end

    assign apply_step = (state == ST_GAP) && pend_valid && !failure;
    assign move_ok    = apply_step && !wall_hit;

`ifdef SNAKE_SELF_HIT_EN
    // Armed only for the pass that follows a committed move; the dropped tail is not walked.
    logic check_pass;

    always_ff @(posedge clk) begin
        if (restart) begin
            check_pass <= 1'b0;
        end else if (state == ST_GAP) begin
            check_pass <= move_ok;
        end
    end

    assign self_hit = check_pass && (state == ST_STREAM) && (widx != 6'd0)
                      && (wx == head_x) && (wy == head_y);
`else
    assign self_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (restart) begin
            state         <= ST_STREAM;
            head_x        <= X_START;
            head_y        <= Y_START;
            head_ptr      <= '0;
            len           <= LEN_START;
            // NOTE: the ring is reset explicitly because the initial body is read from it.
            for (int k = 0; k < MAX_LEN; k++) begin
                ring[k] <= DIR_LEFT;
            end
            wx            <= X_START;
            wy            <= Y_START;
            wptr          <= '0;
            widx          <= '0;
            pend_valid    <= 1'b0;
            pend_dir      <= DIR_UP;
            pend_grow     <= 1'b0;
            judge_pending <= 1'b0;
            snake_x       <= '0;
            snake_y       <= '0;
            snake_dir     <= '0;
            snake_first   <= 1'b0;
            snake_last    <= 1'b0;
            snake_valid   <= 1'b0;
            failure       <= 1'b0;
            success       <= 1'b0;
            step_done     <= 1'b0;
        end else begin
            step_done <= 1'b0;

            if (step && !pend_valid && !failure) begin
                pend_valid <= 1'b1;
                pend_dir   <= step_dir;
                pend_grow  <= grow;
            end

            if (self_hit) begin
                failure <= 1'b1;
            end

            case (state)
                ST_STREAM: begin
                    snake_x     <= wx;
                    snake_y     <= wy;
                    snake_dir   <= walk_dir;
                    snake_first <= (widx == 6'd0);
                    snake_last  <= walk_last;
                    snake_valid <= 1'b1;
                    case (walk_dir)
                        DIR_UP:   wy <= wy - 4'd1;
                        DIR_DOWN: wy <= wy + 4'd1;
                        DIR_LEFT: wx <= wx - 5'd1;
                        default:  wx <= wx + 5'd1;
                    endcase
                    wptr <= wptr - PW'(1);
                    widx <= widx + 6'd1;
                    if (walk_last) begin
                        state <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    snake_valid   <= 1'b0;
                    snake_first   <= 1'b0;
                    snake_last    <= 1'b0;
                    step_done     <= judge_pending;
                    judge_pending <= apply_step;

                    if (pend_valid) begin
                        pend_valid <= 1'b0;
                    end

                    if (apply_step && wall_hit) begin
                        failure <= 1'b1;
                    end

                    if (move_ok) begin
                        head_ptr       <= next_ptr;
                        ring[next_ptr] <= opposite(move_dir);
                        head_x         <= nx[4:0];
                        head_y         <= ny[3:0];
                        if (pend_grow && (len < LEN_MAX)) begin
                            len <= len + 6'd1;
                            if (len + 6'd1 == LEN_MAX) begin
                                success <= 1'b1;
                            end
                        end
                        wx   <= nx[4:0];
                        wy   <= ny[3:0];
                        wptr <= next_ptr;
                    end else begin
                        wx   <= head_x;
                        wy   <= head_y;
                        wptr <= head_ptr;
                    end

                    widx  <= '0;
                    state <= ST_STREAM;
                end

                default: state <= ST_STREAM;
            endcase
        end
    end

    assign snake_head_x = head_x;
    assign snake_head_y = head_y;
    assign length       = len;

endmodule

// File: tb/tb_snake_body.sv
// Directed self-checking bench for snake_body: reset stream, moves, reversal, wall and
// self hits, and a MAX_LEN=4 instance for success and mid-pass restart.
module tb_snake_body;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, game_rst_n, step, grow;
    logic [1:0] step_dir;
    logic [4:0] snake_x, snake_head_x;
    logic [3:0] snake_y, snake_head_y;
    logic [1:0] snake_dir;
    logic       snake_first, snake_last, snake_valid;
    logic [5:0] length;
    logic       failure, success, step_done;

    logic       game_rst_n_s, step_s, grow_s;
    logic [1:0] step_dir_s;
    logic [4:0] snake_x_s, snake_head_x_s;
    logic [3:0] snake_y_s, snake_head_y_s;
    logic [1:0] snake_dir_s;
    logic       snake_first_s, snake_last_s, snake_valid_s;
    logic [5:0] length_s;
    logic       failure_s, success_s, step_done_s;

    int total = 0;
    int bad   = 0;
    int exp_self_fail;

    snake_body dut (
        .clk(clk), .rst_n(rst_n), .game_rst_n(game_rst_n),
        .step(step), .step_dir(step_dir), .grow(grow),
        .snake_x(snake_x), .snake_y(snake_y), .snake_dir(snake_dir),
        .snake_first(snake_first), .snake_last(snake_last), .snake_valid(snake_valid),
        .snake_head_x(snake_head_x), .snake_head_y(snake_head_y), .length(length),
        .failure(failure), .success(success), .step_done(step_done)
    );

    snake_body #(.MAX_LEN(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .game_rst_n(game_rst_n_s),
        .step(step_s), .step_dir(step_dir_s), .grow(grow_s),
        .snake_x(snake_x_s), .snake_y(snake_y_s), .snake_dir(snake_dir_s),
        .snake_first(snake_first_s), .snake_last(snake_last_s), .snake_valid(snake_valid_s),
        .snake_head_x(snake_head_x_s), .snake_head_y(snake_head_y_s), .length(length_s),
        .failure(failure_s), .success(success_s), .step_done(step_done_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sync_first(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (snake_valid && snake_first) seen = 1'b1;
            else tick();
        end
        check(tag, seen, 1);
    endtask

    // Called with segment 0 visible; ends on the gap cycle.
    task automatic expect_pass(input string tag, input int n,
                               input int xs[6], input int ys[6], input int ds[6]);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d].valid", tag, i), snake_valid, 1);
            check($sformatf("%s[%0d].x", tag, i), snake_x, xs[i]);
            check($sformatf("%s[%0d].y", tag, i), snake_y, ys[i]);
            check($sformatf("%s[%0d].dir", tag, i), snake_dir, ds[i]);
            check($sformatf("%s[%0d].first", tag, i), snake_first, (i == 0) ? 1 : 0);
            check($sformatf("%s[%0d].last", tag, i), snake_last, (i == n - 1) ? 1 : 0);
            tick();
        end
        check($sformatf("%s.gap_valid", tag), snake_valid, 0);
    endtask

    // Issues one step and waits for its step_done; ends with segment 0 of the next pass visible.
    task automatic do_step(input string tag, input logic [1:0] d, input logic g);
        logic seen;
        step_dir = d;
        grow     = g;
        step     = 1'b1;
        tick();
        step     = 1'b0;
        grow     = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (step_done) seen = 1'b1;
            else tick();
        end
        check({tag, ".done_seen"}, seen, 1);
        tick();
        check({tag, ".done_pulse"}, step_done, 0);
    endtask

    initial begin
        logic seen;
        rst_n        = 1'b0;
        game_rst_n   = 1'b1;
        step         = 1'b0;
        step_dir     = 2'd0;
        grow         = 1'b0;
        game_rst_n_s = 1'b1;
        step_s       = 1'b0;
        step_dir_s   = 2'd0;
        grow_s       = 1'b0;
`ifdef SNAKE_SELF_HIT_EN
        exp_self_fail = 1;
`else
        exp_self_fail = 0;
`endif
        tick();
        tick();

        // Reset values
        check("rst.valid", snake_valid, 0);
        check("rst.first", snake_first, 0);
        check("rst.last", snake_last, 0);
        check("rst.x", snake_x, 0);
        check("rst.y", snake_y, 0);
        check("rst.dir", snake_dir, 0);
        check("rst.failure", failure, 0);
        check("rst.success", success, 0);
        check("rst.step_done", step_done, 0);
        check("rst.length", length, 3);
        check("rst.head_x", snake_head_x, 5);
        check("rst.head_y", snake_head_y, 7);

        // Reset stream: first segment appears on the first edge after release
        rst_n = 1'b1;
        tick();
        expect_pass("s1a", 3, '{5, 4, 3, 0, 0, 0}, '{7, 7, 7, 0, 0, 0}, '{2, 2, 2, 0, 0, 0});
        tick();
        expect_pass("s1b", 3, '{5, 4, 3, 0, 0, 0}, '{7, 7, 7, 0, 0, 0}, '{2, 2, 2, 0, 0, 0});

        // Move and grow
        tick();
        do_step("s2.right", 2'd3, 1'b0);
        expect_pass("s2a", 3, '{6, 5, 4, 0, 0, 0}, '{7, 7, 7, 0, 0, 0}, '{2, 2, 2, 0, 0, 0});
        check("s2a.length", length, 3);
        do_step("s2.grow", 2'd3, 1'b1);
        expect_pass("s2b", 4, '{7, 6, 5, 4, 0, 0}, '{7, 7, 7, 7, 0, 0}, '{2, 2, 2, 2, 0, 0});
        check("s2b.length", length, 4);
        check("s2b.success", success, 0);

        // Reversal after a game restart
        game_rst_n = 1'b0;
        tick();
        check("s3.rst_valid", snake_valid, 0);
        check("s3.rst_length", length, 3);
        game_rst_n = 1'b1;
        tick();
        do_step("s3.left", 2'd2, 1'b0);
        check("s3.head_x", snake_head_x, 6);
        check("s3.head_y", snake_head_y, 7);
        check("s3.failure", failure, 0);

        // Wall hit: walk to x=18, then one more step right
        for (int k = 0; k < 12; k++) begin
            do_step("s4.walk", 2'd3, 1'b0);
        end
        check("s4.at_edge_x", snake_head_x, 18);
        check("s4.at_edge_fail", failure, 0);
        do_step("s4.wall", 2'd3, 1'b0);
        check("s4.failure", failure, 1);
        check("s4.head_x", snake_head_x, 18);
        check("s4.head_y", snake_head_y, 7);
        sync_first("s4.sync");
        expect_pass("s4", 3, '{18, 17, 16, 0, 0, 0}, '{7, 7, 7, 0, 0, 0}, '{2, 2, 2, 0, 0, 0});
        step_dir = 2'd0;
        step     = 1'b1;
        tick();
        step     = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (step_done) seen = 1'b1;
            tick();
        end
        check("s4.ignored_done", seen, 0);
        check("s4.ignored_head_y", snake_head_y, 7);
        check("s4.still_failed", failure, 1);

        // Self hit
        game_rst_n = 1'b0;
        tick();
        check("s5.rst_failure", failure, 0);
        game_rst_n = 1'b1;
        tick();
        do_step("s5.g1", 2'd3, 1'b1);
        do_step("s5.g2", 2'd3, 1'b1);
        check("s5.length", length, 5);
        check("s5.head_x", snake_head_x, 7);
        do_step("s5.up", 2'd0, 1'b0);
        do_step("s5.left", 2'd2, 1'b0);
        check("s5.pre_fail", failure, 0);
        check("s5.pre_head_x", snake_head_x, 6);
        check("s5.pre_head_y", snake_head_y, 6);
        step_dir = 2'd1;
        step     = 1'b1;
        tick();
        step     = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (step_done) seen = 1'b1;
            else tick();
        end
        check("s5.down.done_seen", seen, 1);
        check("s5.failure", failure, exp_self_fail);
        check("s5.head_y", snake_head_y, 7);

        // Full body and mid-pass restart on the MAX_LEN=4 instance
        check("s6.pre_success", success_s, 0);
        step_dir_s = 2'd3;
        grow_s     = 1'b1;
        step_s     = 1'b1;
        tick();
        step_s     = 1'b0;
        grow_s     = 1'b0;
        seen       = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (step_done_s) seen = 1'b1;
            else tick();
        end
        check("s6.done_seen", seen, 1);
        check("s6.success", success_s, 1);
        check("s6.length", length_s, 4);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (snake_valid_s && snake_first_s) seen = 1'b1;
            else tick();
        end
        check("s6.sync", seen, 1);
        tick();
        check("s6.mid_valid", snake_valid_s, 1);
        check("s6.mid_first", snake_first_s, 0);
        game_rst_n_s = 1'b0;
        tick();
        check("s6.rst_valid", snake_valid_s, 0);
        check("s6.rst_success", success_s, 0);
        check("s6.rst_length", length_s, 3);
        game_rst_n_s = 1'b1;
        tick();
        check("s6.r0.x", snake_x_s, 5);
        check("s6.r0.first", snake_first_s, 1);
        tick();
        check("s6.r1.x", snake_x_s, 4);
        check("s6.r1.valid", snake_valid_s, 1);
        tick();
        check("s6.r2.x", snake_x_s, 3);
        check("s6.r2.last", snake_last_s, 1);
        tick();
        check("s6.gap_valid", snake_valid_s, 0);
        tick();
        check("s6.repeat_first", snake_first_s, 1);
        check("s6.repeat_y", snake_y_s, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
